// File: rtl/keypad_pkg.sv
// Shared types and key decode helpers for the 4x4 keypad scanner.
// Optional auto-repeat is enabled in keypad_scanner via KEYPAD_REPEAT_EN.
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        HOLD,
        RELEASE
    } state_t;

    typedef logic [3:0] key_code_t;

    // Nibble (row*4 + col) holds the key code; digits are their value, A-D are 10-13.
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    localparam key_code_t KEY_STAR    = 4'hE;
    localparam key_code_t KEY_HASH    = 4'hF;
    localparam key_code_t KEY_OP_BASE = 4'hA;

    localparam logic [1:0] OP_A = 2'd0;
    localparam logic [1:0] OP_B = 2'd1;
    localparam logic [1:0] OP_C = 2'd2;
    localparam logic [1:0] OP_D = 2'd3;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic key_code_t decode_key(input logic [3:0] row_oh, input logic [3:0] col_oh);
        logic [5:0] base;
        base = {onehot_index(row_oh), onehot_index(col_oh), 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

    function automatic logic is_digit(input key_code_t k);
        return k <= 4'd9;
    endfunction

    function automatic logic [1:0] op_code(input key_code_t k);
        key_code_t d;
        d = k - KEY_OP_BASE;
        return d[1:0];
    endfunction

endpackage

// File: rtl/keypad_sync_debounce.sv
// Two-flop row synchroniser plus a stable-cycle counter that reports when the
// synchronised rows have matched the target for DEBOUNCE_CNT consecutive cycles.
module keypad_sync_debounce #(
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    input  logic [3:0] target,
    input  logic       enable,
    input  logic       clear,
    output logic [3:0] rs,
    output logic       match,
    output logic       done
);

    localparam int CW = $clog2(DEBOUNCE_CNT) + 1;

    logic [3:0]    meta_reg;
    logic [3:0]    rs_reg;
    logic [CW-1:0] count_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
        always_ff @(posedge clk) begin
            if (rst) begin
                meta_reg[gi] <= 1'b0;
                rs_reg[gi]   <= 1'b0;
            end else begin
                meta_reg[gi] <= row[gi];
                rs_reg[gi]   <= meta_reg[gi];
            end
        end
    end

    // Clear wins so every state entry starts from zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable && match) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign rs    = rs_reg;
    assign match = (rs_reg == target);
    assign done  = enable && match && (count_reg == CW'(DEBOUNCE_CNT - 1));

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, debounce, and one-cycle command strobes.
// Define KEYPAD_REPEAT_EN to let held digit keys auto-repeat every REPEAT_CYCLES.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE_CNT  = 50000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] digit,
    output logic       store_digit,
    output logic       enter,
    output logic       clear,
    output logic       op_valid,
    output logic [1:0] op
);

    localparam int SW = $clog2(SCAN_DIV) + 1;

    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("keypad_scanner: SCAN_DIV, DEBOUNCE_CNT and REPEAT_CYCLES must be >= 2");
    end

    state_t        state_reg, state_next;
    logic [3:0]    col_reg, col_next;
    logic [3:0]    row_lat_reg, row_lat_next;
    key_code_t     key_reg, key_next;
    logic [SW-1:0] scan_cnt_reg, scan_cnt_next;
    logic [3:0]    digit_reg, digit_next;
    logic [1:0]    op_reg, op_next;
    logic          store_digit_reg, store_digit_next;
    logic          enter_reg, enter_next;
    logic          clear_reg, clear_next;
    logic          op_valid_reg, op_valid_next;

    logic [3:0]    rs;
    logic [3:0]    deb_target;
    logic          deb_enable;
    logic          deb_clear;
    logic          deb_match;
    logic          deb_done;
    logic          repeat_fire;

    // DEBOUNCE waits for the latched row to stay put; RELEASE waits for all rows low.
    assign deb_target = (state_reg == RELEASE) ? 4'd0 : row_lat_reg;
    assign deb_enable = (state_reg == DEBOUNCE) || (state_reg == RELEASE);
    assign deb_clear  = (state_next != state_reg);

    keypad_sync_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_sync_debounce (
        .clk   (clk),
        .rst   (rst),
        .row   (row),
        .target(deb_target),
        .enable(deb_enable),
        .clear (deb_clear),
        .rs    (rs),
        .match (deb_match),
        .done  (deb_done)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;

    logic [RW-1:0] rep_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || state_reg != HOLD || state_next != HOLD) begin
            rep_cnt_reg <= '0;
        end else begin
            rep_cnt_reg <= rep_cnt_reg + 1'b1;
        end
    end

    // Firing one cycle early lets the EMIT cycle complete the repeat period.
    assign repeat_fire = (state_reg == HOLD) && is_digit(key_reg) &&
                         (rep_cnt_reg == RW'(REPEAT_CYCLES - 2));
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= SCAN;
            col_reg         <= 4'b0001;
            row_lat_reg     <= 4'd0;
            key_reg         <= 4'd0;
            scan_cnt_reg    <= '0;
            digit_reg       <= 4'd0;
            op_reg          <= OP_A;
            store_digit_reg <= 1'b0;
            enter_reg       <= 1'b0;
            clear_reg       <= 1'b0;
            op_valid_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            col_reg         <= col_next;
            row_lat_reg     <= row_lat_next;
            key_reg         <= key_next;
            scan_cnt_reg    <= scan_cnt_next;
            digit_reg       <= digit_next;
            op_reg          <= op_next;
            store_digit_reg <= store_digit_next;
            enter_reg       <= enter_next;
            clear_reg       <= clear_next;
            op_valid_reg    <= op_valid_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        col_next         = col_reg;
        row_lat_next     = row_lat_reg;
        key_next         = key_reg;
        scan_cnt_next    = scan_cnt_reg;
        digit_next       = digit_reg;
        op_next          = op_reg;
        store_digit_next = 1'b0;
        enter_next       = 1'b0;
        clear_next       = 1'b0;
        op_valid_next    = 1'b0;

        case (state_reg)
            SCAN: begin
                if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
                    scan_cnt_next = '0;
                    if (is_onehot(rs)) begin
                        row_lat_next = rs;
                        key_next     = decode_key(rs, col_reg);
                        state_next   = DEBOUNCE;
                    end else begin
                        col_next = {col_reg[2:0], col_reg[3]};
                    end
                end else begin
                    scan_cnt_next = scan_cnt_reg + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!deb_match) begin
                    state_next = SCAN;
                    col_next   = {col_reg[2:0], col_reg[3]};
                end else if (deb_done) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                state_next = HOLD;
                if (is_digit(key_reg)) begin
                    store_digit_next = 1'b1;
                    digit_next       = key_reg;
                end else if (key_reg == KEY_HASH) begin
                    enter_next = 1'b1;
                end else if (key_reg == KEY_STAR) begin
                    clear_next = 1'b1;
                end else begin
                    op_valid_next = 1'b1;
                    op_next       = op_code(key_reg);
                end
            end
            HOLD: begin
                if (rs == 4'd0) begin
                    state_next = RELEASE;
                end else if (repeat_fire) begin
                    state_next = EMIT;
                end
            end
            RELEASE: begin
                if (!deb_match) begin
                    state_next = HOLD;
                end else if (deb_done) begin
                    state_next = SCAN;
                    col_next   = {col_reg[2:0], col_reg[3]};
                end
            end
            default: begin
                state_next = SCAN;
                col_next   = 4'b0001;
            end
        endcase
    end

    assign col         = col_reg;
    assign digit       = digit_reg;
    assign op          = op_reg;
    assign store_digit = store_digit_reg;
    assign enter       = enter_reg;
    assign clear       = clear_reg;
    assign op_valid    = op_valid_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from the column
// drive, stimulus queues expected strobes, and a monitor checks every strobe seen.
module tb_keypad_scanner;

    localparam logic [1:0] K_DIGIT = 2'd0;
    localparam logic [1:0] K_ENTER = 2'd1;
    localparam logic [1:0] K_CLEAR = 2'd2;
    localparam logic [1:0] K_OP    = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] dig;
        logic [1:0] opc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] digit;
    logic       store_digit;
    logic       enter;
    logic       clear;
    logic       op_valid;
    logic [1:0] op;

    logic [3:0] key_rows = 4'd0;
    logic [3:0] key_cols = 4'd0;

    exp_t exp_q[$];
    int   strobe_cyc[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Directed key table: rows, cols, expected kind, digit and op after the press.
    logic [3:0] tbl_row  [8] = '{4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] tbl_col  [8] = '{4'b0100, 4'b1000, 4'b1000, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b1000};
    logic [1:0] tbl_kind [8] = '{K_ENTER, K_OP,    K_OP,    K_DIGIT, K_CLEAR, K_OP,    K_DIGIT, K_OP};
    logic [3:0] tbl_dig  [8] = '{4'd5,    4'd5,    4'd5,    4'd0,    4'd0,    4'd0,    4'd9,    4'd9};
    logic [1:0] tbl_op   [8] = '{2'd0,    2'd0,    2'd2,    2'd2,    2'd2,    2'd1,    2'd1,    2'd3};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8),
        .REPEAT_CYCLES(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .digit      (digit),
        .store_digit(store_digit),
        .enter      (enter),
        .clear      (clear),
        .op_valid   (op_valid),
        .op         (op)
    );

    // Keypad model: a pressed key connects its row lines to its column drive.
    initial begin
        forever begin
            row = ((col & key_cols) != 4'd0) ? key_rows : 4'd0;
            @(col or key_rows or key_cols);
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic exp_t make_exp(input logic [1:0] k, input logic [3:0] d, input logic [1:0] o);
        exp_t e;
        e.kind = k;
        e.dig  = d;
        e.opc  = o;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_col(input logic [3:0] target, input int budget, input string name);
        int i;
        i = 0;
        while (col !== target && i < budget) begin
            tick(1);
            i++;
        end
        check(name, int'(col), int'(target));
    endtask

    task automatic wait_col_change(input int budget, input string name, output logic [3:0] new_col);
        logic [3:0] old_col;
        int i;
        old_col = col;
        i = 0;
        while (col === old_col && i < budget) begin
            tick(1);
            i++;
        end
        new_col = col;
        check(name, int'(col != old_col), 1);
    endtask

    task automatic press(input logic [3:0] r, input logic [3:0] c, input int hold, input int rel);
        key_rows = r;
        key_cols = c;
        tick(hold);
        key_rows = 4'd0;
        key_cols = 4'd0;
        tick(rel);
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    initial begin : monitor
        int         n_hi;
        logic [1:0] kind;
        exp_t       e;
        forever begin
            @(negedge clk);
            n_hi = int'(store_digit) + int'(enter) + int'(clear) + int'(op_valid);
            if (n_hi != 0) begin
                kind = store_digit ? K_DIGIT : enter ? K_ENTER : clear ? K_CLEAR : K_OP;
                check("strobe_exclusive", n_hi, 1);
                if (store_digit) strobe_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_strobe: got kind %0d digit %0d op %0d at cycle %0d, required no strobe",
                             kind, digit, op, cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("strobe kind=%0d digit=%0d op=%0d cycle=%0d", kind, digit, op, cyc);
                    check("strobe_kind", int'(kind), int'(e.kind));
                    check("digit_value", int'(digit), int'(e.dig));
                    check("op_value", int'(op), int'(e.opc));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [3:0] c;
        logic [3:0] nc;

        rst = 1'b1;
        tick(2);
        check("reset_col", int'(col), 1);
        check("reset_digit", int'(digit), 0);
        check("reset_op", int'(op), 0);
        check("reset_strobes", int'({store_digit, enter, clear, op_valid}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("col_dwell", int'(col), 1);
        tick(1);
        check("col_advance", int'(col), 2);

        // '5' held long: one strobe, column frozen while held.
        exp_q.push_back(make_exp(K_DIGIT, 4'd5, 2'd0));
        key_rows = 4'b0010;
        key_cols = 4'b0010;
        tick(40);
        $display("press '5' held 40 cycles, col=%b", col);
        check("hold_col_frozen", int'(col), 2);
        check("press_5_seen", exp_q.size(), 0);
        key_rows = 4'd0;
        key_cols = 4'd0;
        tick(20);

        // Bounce: a 3-cycle pulse on r0 right after a column change.
        wait_col_change(10, "bounce_col_change", c);
        key_cols = c;
        key_rows = 4'b0001;
        tick(3);
        key_rows = 4'd0;
        key_cols = 4'd0;
        nc = {c[2:0], c[3]};
        wait_col(nc, 5, "bounce_next_col");
        $display("bounce on col %b, resumed at col %b", c, col);
        tick(20);

        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(make_exp(tbl_kind[i], tbl_dig[i], tbl_op[i]));
            press(tbl_row[i], tbl_col[i], 50, 24);
            $display("key %0d rows=%b cols=%b pending=%0d", i, tbl_row[i], tbl_col[i], exp_q.size());
            check($sformatf("key_%0d_seen", i), exp_q.size(), 0);
        end

        // Two rows in one column: not one-hot, scanning must continue.
        key_rows = 4'b0101;
        key_cols = 4'b0001;
        tick(40);
        wait_col_change(5, "multihot_scanning", c);
        $display("multi-hot r0+r2 on c0, scanning col=%b", c);
        key_rows = 4'd0;
        key_cols = 4'd0;
        tick(20);

        // Reset in the middle of debouncing '8' (r2/c1).
        wait_col(4'b0001, 20, "rst_align_c0");
        key_rows = 4'b0100;
        key_cols = 4'b0010;
        wait_col(4'b0010, 8, "rst_align_c1");
        tick(6);
        check("debounce_col_frozen", int'(col), 2);
        rst = 1'b1;
        tick(2);
        key_rows = 4'd0;
        key_cols = 4'd0;
        check("midrst_col", int'(col), 1);
        check("midrst_digit", int'(digit), 0);
        check("midrst_op", int'(op), 0);
        @(negedge clk);
        rst = 1'b0;
        tick(30);
        $display("reset during debounce, col=%b digit=%0d", col, digit);

`ifdef KEYPAD_REPEAT_EN
        // '7' held 170 cycles: press strobe plus repeats 64 and 128 cycles later.
        strobe_cyc.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(make_exp(K_DIGIT, 4'd7, 2'd0));
        press(4'b0100, 4'b0001, 170, 24);
        check("repeat_7_seen", exp_q.size(), 0);
        check("repeat_7_count", strobe_cyc.size(), 3);
        for (int i = 1; i < strobe_cyc.size(); i++) begin
            check($sformatf("repeat_gap_%0d", i), strobe_cyc[i] - strobe_cyc[i-1], 64);
        end
        exp_q.push_back(make_exp(K_CLEAR, 4'd7, 2'd0));
        press(4'b1000, 4'b0001, 170, 24);
        check("clear_no_repeat", exp_q.size(), 0);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
